// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcodes, instruction format codes and field positions shared by the decode stage
package riscv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL} fmt_e;
  function automatic fmt_e decode_fmt(input logic [6:0] op);
    return op == OP_R ? FMT_R :
           (op == OP_IMM || op == OP_LOAD || op == OP_JALR || op == OP_SYS) ? FMT_I :
           op == OP_STORE ? FMT_S :
           op == OP_BRANCH ? FMT_B :
           (op == OP_LUI || op == OP_AUIPC) ? FMT_U :
           op == OP_JAL ? FMT_J : FMT_ILL;
  endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended immediate for each RV32I instruction format
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);
  logic [31:0] i32;
  assign i32 = fmt == FMT_I ? {{20{instr[31]}}, instr[31:20]} :
               fmt == FMT_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
               fmt == FMT_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
               fmt == FMT_U ? {instr[31:12], 12'b0} :
               fmt == FMT_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
               32'b0;
  assign imm = XLEN'($signed(i32));
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: circular fetch buffer feeding a combinational RV32I field decoder
module if_id_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [PC_W-1:0] mem_pc    [DEPTH];
  logic [31:0]     mem_instr [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic            push, pop;
  logic [31:0]     hd;
  fmt_e            f;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign in_ready  = cnt < CW'(DEPTH);
  assign out_valid = cnt != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop) rd_ptr <= inc(rd_ptr);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  // storage is deliberately unreset; the control state alone decides what is visible
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= in_pc;
      mem_instr[wr_ptr] <= in_instr;
    end
  end
  always_comb begin
    hd      = out_valid ? mem_instr[rd_ptr] : '0;
    f       = decode_fmt(hd[6:0]);
    out_pc  = out_valid ? mem_pc[rd_ptr] : '0;
    opcode  = hd[6:0];
    rd      = (f == FMT_S || f == FMT_B) ? '0 : hd[RD_LSB +: 5];
    rs1     = (f == FMT_U || f == FMT_J) ? '0 : hd[RS1_LSB +: 5];
    funct3  = (f == FMT_U || f == FMT_J) ? '0 : hd[F3_LSB +: 3];
    rs2     = (f == FMT_I || f == FMT_U || f == FMT_J) ? '0 : hd[RS2_LSB +: 5];
    funct7  = (f == FMT_I || f == FMT_U || f == FMT_J) ? '0 : hd[F7_LSB +: 7];
    fmt     = out_valid ? f : FMT_R;
    illegal = out_valid && f == FMT_ILL;
  end
  imm_gen #(.XLEN(XLEN)) u_imm (.instr(hd), .fmt(f), .imm(imm));
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed scenario tests for the fetch buffer and decoder
module tb_if_id_stage;
  import riscv_pkg::*;
  logic        clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic [31:0] in_pc = 0, in_instr = 0;
  logic        in_ready, out_valid, illegal;
  logic [31:0] out_pc, imm;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  fmt_e        fmt;
  int          errs = 0, checks = 0;

  if_id_stage #(.XLEN(32), .PC_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .fmt(fmt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi_w(input int i);
    return {12'(i), 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  task automatic test_reset;
    #3;
    checks++;
    if ({in_ready, out_valid, out_pc, opcode, rd, rs1, rs2, funct3, funct7, imm, fmt, illegal} !== {1'b1, 1'b0, 32'h0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0, FMT_R, 1'b0}) begin
      errs++;
      $display("FAIL reset: got in_ready=%0b out_valid=%0b pc=%h op=%h fmt=%0d imm=%h ill=%0b, want 1 0 0 0 0 0 0", in_ready, out_valid, out_pc, opcode, fmt, imm, illegal);
    end
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_i_type;
    in_valid = 1; in_pc = 32'h100; in_instr = 32'h00500093; out_ready = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL i_pre_valid: got %0b want 0", out_valid); end
    tick;
    in_valid = 0;
    checks++;
    if ({out_valid, out_pc, opcode, rd, rs1, rs2, funct7, fmt, imm, illegal} !== {1'b1, 32'h100, 7'h13, 5'd1, 5'd0, 5'd0, 7'h0, FMT_I, 32'h5, 1'b0}) begin
      errs++;
      $display("FAIL i_type: got v=%0b pc=%h op=%h rd=%0d rs1=%0d rs2=%0d f7=%h fmt=%0d imm=%h, want 1 100 13 1 0 0 0 1 00000005", out_valid, out_pc, opcode, rd, rs1, rs2, funct7, fmt, imm);
    end
    tick;
    checks++;
    if ({out_valid, out_pc, imm} !== {1'b1, 32'h100, 32'h5}) begin
      errs++;
      $display("FAIL i_hold: got v=%0b pc=%h imm=%h want 1 100 00000005", out_valid, out_pc, imm);
    end
    out_ready = 1;
    tick;
    out_ready = 0;
    checks++;
    if ({out_valid, out_pc, imm} !== {1'b0, 32'h0, 32'h0}) begin
      errs++;
      $display("FAIL i_pop: got v=%0b pc=%h imm=%h want 0 0 0", out_valid, out_pc, imm);
    end
  endtask

  task automatic test_s_b;
    in_valid = 1; in_pc = 32'h110; in_instr = 32'h0020A423;
    tick;
    in_pc = 32'h114; in_instr = 32'hFE000EE3;
    checks++;
    if ({opcode, fmt, rd, rs1, rs2, funct3, imm} !== {7'h23, FMT_S, 5'd0, 5'd1, 5'd2, 3'd2, 32'h8}) begin
      errs++;
      $display("FAIL s_type: got op=%h fmt=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d imm=%h want 23 2 0 1 2 2 00000008", opcode, fmt, rd, rs1, rs2, funct3, imm);
    end
    tick;
    in_valid = 0; out_ready = 1;
    tick;
    checks++;
    if ({out_pc, fmt, rd, imm} !== {32'h114, FMT_B, 5'd0, 32'hFFFFFFFC}) begin
      errs++;
      $display("FAIL b_type: got pc=%h fmt=%0d rd=%0d imm=%h want 114 3 0 fffffffc", out_pc, fmt, rd, imm);
    end
    tick;
    out_ready = 0;
  endtask

  task automatic test_u_ill;
    in_valid = 1; in_pc = 32'h120; in_instr = 32'h123452B7;
    tick;
    in_pc = 32'h124; in_instr = 32'h0000007F;
    checks++;
    if ({fmt, rd, rs1, funct3, rs2, imm, illegal} !== {FMT_U, 5'd5, 5'd0, 3'd0, 5'd0, 32'h12345000, 1'b0}) begin
      errs++;
      $display("FAIL u_type: got fmt=%0d rd=%0d rs1=%0d f3=%0d rs2=%0d imm=%h ill=%0b want 4 5 0 0 0 12345000 0", fmt, rd, rs1, funct3, rs2, imm, illegal);
    end
    tick;
    in_valid = 0; out_ready = 1;
    tick;
    checks++;
    if ({out_pc, fmt, illegal, imm} !== {32'h124, FMT_ILL, 1'b1, 32'h0}) begin
      errs++;
      $display("FAIL ill: got pc=%h fmt=%0d ill=%0b imm=%h want 124 6 1 0", out_pc, fmt, illegal, imm);
    end
    tick;
    out_ready = 0;
  endtask

  task automatic test_back_to_back;
    int q[$];
    int nxt;
    out_ready = 0; in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      in_pc = 32'h200 + 32'(4 * k); in_instr = addi_w(k);
      #1;
      checks++;
      if (in_ready !== (k < 2)) begin errs++; $display("FAIL bp_ready%0d: got %0b want %0b", k, in_ready, k < 2); end
      tick;
    end
    checks++;
    if ({in_ready, out_valid, out_pc} !== {1'b0, 1'b1, 32'h200}) begin
      errs++;
      $display("FAIL bp_full: got in_ready=%0b v=%0b pc=%h want 0 1 200", in_ready, out_valid, out_pc);
    end
    q = '{0, 1};
    nxt = 2;
    out_ready = 1;
    for (int cyc = 0; cyc < 40 && (nxt < 8 || q.size() != 0); cyc++) begin
      in_valid = nxt < 8;
      in_pc = 32'h200 + 32'(4 * nxt); in_instr = addi_w(nxt);
      #1;
      checks++;
      if (out_valid !== (q.size() != 0)) begin
        errs++;
        $display("FAIL bp_valid: got %0b want %0b", out_valid, q.size() != 0);
      end
      if (out_valid && q.size() != 0) begin
        checks++;
        if ({out_pc, imm} !== {32'h200 + 32'(4 * q[0]), 32'(q[0])}) begin
          errs++;
          $display("FAIL bp_order: got pc=%h imm=%h want pc=%h imm=%h", out_pc, imm, 32'h200 + 32'(4 * q[0]), q[0]);
        end
        void'(q.pop_front());
      end
      if (in_valid && in_ready) begin q.push_back(nxt); nxt++; end
      tick;
    end
    in_valid = 0; out_ready = 0;
    checks++;
    if (nxt != 8 || q.size() != 0) begin
      errs++;
      $display("FAIL bp_timeout: got pushed=%0d pending=%0d want 8 0", nxt, q.size());
    end
  endtask

  task automatic test_flush;
    in_valid = 1; out_ready = 0;
    in_pc = 32'h300; in_instr = addi_w(1);
    tick;
    in_pc = 32'h304; in_instr = addi_w(2);
    tick;
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin errs++; $display("FAIL fl_full: got v=%0b in_ready=%0b want 1 0", out_valid, in_ready); end
    flush = 1; out_ready = 1; in_pc = 32'h308; in_instr = addi_w(3);
    tick;
    flush = 0; in_valid = 0;
    checks++;
    if ({out_valid, in_ready, out_pc} !== {1'b0, 1'b1, 32'h0}) begin
      errs++;
      $display("FAIL fl_clear: got v=%0b in_ready=%0b pc=%h want 0 1 0", out_valid, in_ready, out_pc);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL fl_absent: got v=%0b want 0", out_valid); end
    out_ready = 0; in_valid = 1; in_pc = 32'h310; in_instr = addi_w(4);
    tick;
    flush = 1; in_pc = 32'h314; in_instr = addi_w(5);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL fl_ready: got %0b want 1", in_ready); end
    tick;
    flush = 0; in_valid = 0;
    checks++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL fl_push_drop: got v=%0b want 0", out_valid); end
  endtask

  task automatic test_async_reset;
    in_valid = 1; in_pc = 32'h400; in_instr = addi_w(7);
    tick;
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1) begin errs++; $display("FAIL ar_pre: got v=%0b want 1", out_valid); end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({out_valid, in_ready, out_pc, imm} !== {1'b0, 1'b1, 32'h0, 32'h0}) begin
      errs++;
      $display("FAIL ar_async: got v=%0b in_ready=%0b pc=%h imm=%h want 0 1 0 0", out_valid, in_ready, out_pc, imm);
    end
    @(posedge clk);
    #1 rst_n = 1;
    in_valid = 1; in_pc = 32'h404; in_instr = 32'h123452B7;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL ar_empty: got v=%0b want 0", out_valid); end
    tick;
    in_valid = 0;
    checks++;
    if ({out_valid, out_pc, fmt, imm} !== {1'b1, 32'h404, FMT_U, 32'h12345000}) begin
      errs++;
      $display("FAIL ar_refill: got v=%0b pc=%h fmt=%0d imm=%h want 1 404 4 12345000", out_valid, out_pc, fmt, imm);
    end
  endtask

  initial begin
    test_reset;
    test_i_type;
    test_s_b;
    test_u_ill;
    test_back_to_back;
    test_flush;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
